de2_115_sopc_sysid_master: RTL and testbench



---
 rtl/sysid_master_pkg.sv | 16 +
 rtl/de2_115_sopc_sysid_master.sv | 150 +++++++++++++++
 tb/tb_de2_115_sopc_sysid_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sysid_master_pkg.sv
// Shared types and constants for the sysid checking master.
package sysid_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    FINISH
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int STALL_W = 16;

endpackage

// File: rtl/de2_115_sopc_sysid_master.sv
// Reads the two sysid words over Avalon-MM and compares them against expected values.
// Optional SYSID_MASTER_PERIODIC_EN adds periodic auto-checks and a sticky mismatch output.
module de2_115_sopc_sysid_master
  import sysid_master_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1513105036,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SYSID_MASTER_PERIODIC_EN
  ,
  output logic        mismatch
`endif
);

  localparam logic [STALL_W-1:0] TIMEOUT_LIM = STALL_W'(TIMEOUT_CYCLES);

  state_e             state_q;
  logic               read_q;
  logic               address_q;
  logic               busy_q;
  logic               done_q;
  logic               id_ok_q;
  logic               ts_ok_q;
  logic               timeout_q;
  logic [31:0]        id_value_q;
  logic [31:0]        ts_value_q;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;
  logic               trigger;

  assign stall_d = stall_q + 1'b1;

`ifdef SYSID_MASTER_PERIODIC_EN
  logic [23:0] period_q;
  logic        mismatch_q;

  // Free-running only while idle, so a check fires after 2^24 consecutive idle cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (state_q == IDLE) period_q <= period_q + 24'd1;
      else                 period_q <= '0;
      if (state_q == FINISH && (!id_ok_q || !ts_ok_q || timeout_q)) mismatch_q <= 1'b1;
    end
  end

  assign trigger  = start | ((state_q == IDLE) && (period_q == '1));
  assign mismatch = mismatch_q;
`else
  assign trigger = start;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      address_q  <= ADDR_ID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      stall_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q   <= RD_ID;
            read_q    <= 1'b1;
            address_q <= ADDR_ID;
            busy_q    <= 1'b1;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_value_q <= avm_readdata;
            id_ok_q    <= (avm_readdata == EXPECTED_ID);
            address_q  <= ADDR_TS;
            stall_q    <= '0;
            state_q    <= RD_TS;
          end else if (stall_d == TIMEOUT_LIM) begin
            timeout_q <= 1'b1;
            read_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end else begin
            stall_q <= stall_d;
          end
        end
        RD_TS: begin
          if (!avm_waitrequest) begin
            ts_value_q <= avm_readdata;
            ts_ok_q    <= (avm_readdata == EXPECTED_TS);
            read_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FINISH;
          end else if (stall_d == TIMEOUT_LIM) begin
            timeout_q <= 1'b1;
            read_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end else begin
            stall_q <= stall_d;
          end
        end
        FINISH: begin
          busy_q    <= 1'b0;
          address_q <= ADDR_ID;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_address = address_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_de2_115_sopc_sysid_master.sv
// Bench for de2_115_sopc_sysid_master: two instances (default timeout and a short timeout)
// driven by a configurable stalling slave and checked against a per-sequence schedule model.
module tb_de2_115_sopc_sysid_master;

  localparam int          TO_A   = 255;
  localparam int          TO_B   = 4;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1513105036;
  localparam int          STUCK  = 1000000;

  logic             clock;
  logic             resetN;
  logic [1:0]       startV;
  logic [1:0]       avmAddress;
  logic [1:0]       avmRead;
  logic [1:0]       waitReq;
  logic [1:0][31:0] readData;
  logic [1:0]       busyV;
  logic [1:0]       doneV;
  logic [1:0]       idOkV;
  logic [1:0]       tsOkV;
  logic [1:0]       tmoV;
  logic [1:0][31:0] idVal;
  logic [1:0][31:0] tsVal;
`ifdef SYSID_MASTER_PERIODIC_EN
  logic [1:0]       mismatchV;
`endif

  int          stallCfg [2][2];
  logic [31:0] dataCfg  [2][2];
  logic [31:0] prevId   [2];
  logic [31:0] prevTs   [2];

  int vectors;
  int miscompares;

  de2_115_sopc_sysid_master #(.TIMEOUT_CYCLES(TO_A)) dutA (
    .clock(clock), .reset_n(resetN), .start(startV[0]),
    .avm_address(avmAddress[0]), .avm_read(avmRead[0]),
    .avm_waitrequest(waitReq[0]), .avm_readdata(readData[0]),
    .busy(busyV[0]), .done(doneV[0]), .id_ok(idOkV[0]), .ts_ok(tsOkV[0]),
    .timeout(tmoV[0]), .id_value(idVal[0]), .ts_value(tsVal[0])
`ifdef SYSID_MASTER_PERIODIC_EN
    , .mismatch(mismatchV[0])
`endif
  );

  de2_115_sopc_sysid_master #(.TIMEOUT_CYCLES(TO_B)) dutB (
    .clock(clock), .reset_n(resetN), .start(startV[1]),
    .avm_address(avmAddress[1]), .avm_read(avmRead[1]),
    .avm_waitrequest(waitReq[1]), .avm_readdata(readData[1]),
    .busy(busyV[1]), .done(doneV[1]), .id_ok(idOkV[1]), .ts_ok(tsOkV[1]),
    .timeout(tmoV[1]), .id_value(idVal[1]), .ts_value(tsVal[1])
`ifdef SYSID_MASTER_PERIODIC_EN
    , .mismatch(mismatchV[1])
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave: stalls a configured number of cycles per word, then returns that word's data.
  for (genvar g = 0; g < 2; g++) begin : gSlave
    int cnt;
    always @(posedge clock or negedge resetN) begin
      if (!resetN)                       cnt <= 0;
      else if (avmRead[g] && waitReq[g]) cnt <= cnt + 1;
      else                               cnt <= 0;
    end
    assign waitReq[g]  = avmRead[g] && (cnt < stallCfg[g][avmAddress[g]]);
    assign readData[g] = dataCfg[g][avmAddress[g]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one check sequence on instance d and compares cycle-by-cycle against the expected schedule.
  task automatic applyStimulus(input int d, input int sId, input int sTs,
                               input logic [31:0] vId, input logic [31:0] vTs);
    int          lim;
    bit          idTo, tsTo, reStart;
    bit          expRd[$];
    bit          expAd[$];
    bit          expDn[$];
    logic [31:0] eId, eTs;
    lim = (d == 0) ? TO_A : TO_B;
    stallCfg[d][0] = sId;
    stallCfg[d][1] = sTs;
    dataCfg[d][0]  = vId;
    dataCfg[d][1]  = vTs;
    idTo = (sId >= lim);
    tsTo = !idTo && (sTs >= lim);
    eId  = idTo ? prevId[d] : vId;
    eTs  = (idTo || tsTo) ? prevTs[d] : vTs;
    for (int i = 0; i < (idTo ? lim : sId + 1); i++) begin
      expRd.push_back(1'b1); expAd.push_back(1'b0); expDn.push_back(1'b0);
    end
    if (!idTo) begin
      for (int i = 0; i < (tsTo ? lim : sTs + 1); i++) begin
        expRd.push_back(1'b1); expAd.push_back(1'b1); expDn.push_back(1'b0);
      end
    end
    expRd.push_back(1'b0); expAd.push_back(1'b0); expDn.push_back(1'b1);
    reStart = 1'($urandom_range(0, 1));
    @(negedge clock);
    startV[d] = 1'b1;
    foreach (expRd[i]) begin
      @(negedge clock);
      if (i == 0) startV[d] = 1'b0;
      if (i == 1 && reStart) startV[d] = 1'b1;
      if (i == 2) startV[d] = 1'b0;
      checkOutput($sformatf("d%0d c%0d read", d, i), 32'(avmRead[d]), 32'(expRd[i]));
      if (expRd[i]) checkOutput($sformatf("d%0d c%0d addr", d, i), 32'(avmAddress[d]), 32'(expAd[i]));
      checkOutput($sformatf("d%0d c%0d done", d, i), 32'(doneV[d]), 32'(expDn[i]));
      checkOutput($sformatf("d%0d c%0d busy", d, i), 32'(busyV[d]), 32'd1);
    end
    @(negedge clock);
    checkOutput($sformatf("d%0d idle busy", d), 32'(busyV[d]), 32'd0);
    checkOutput($sformatf("d%0d idle done", d), 32'(doneV[d]), 32'd0);
    checkOutput($sformatf("d%0d idle read", d), 32'(avmRead[d]), 32'd0);
    checkOutput($sformatf("d%0d id_value", d), idVal[d], eId);
    checkOutput($sformatf("d%0d ts_value", d), tsVal[d], eTs);
    checkOutput($sformatf("d%0d id_ok", d), 32'(idOkV[d]), 32'(!idTo && (vId == EXP_ID)));
    checkOutput($sformatf("d%0d ts_ok", d), 32'(tsOkV[d]), 32'(!idTo && !tsTo && (vTs == EXP_TS)));
    checkOutput($sformatf("d%0d timeout", d), 32'(tmoV[d]), 32'(idTo || tsTo));
    prevId[d] = eId;
    prevTs[d] = eTs;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetN      = 1'b0;
    startV      = '0;
    for (int d = 0; d < 2; d++) begin
      prevId[d] = '0;
      prevTs[d] = '0;
      for (int w = 0; w < 2; w++) begin
        stallCfg[d][w] = 0;
        dataCfg[d][w]  = '0;
      end
    end
    repeat (2) @(negedge clock);

    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d reset read", d), 32'(avmRead[d]), 32'd0);
      checkOutput($sformatf("d%0d reset busy", d), 32'(busyV[d]), 32'd0);
      checkOutput($sformatf("d%0d reset oks", d), {29'd0, idOkV[d], tsOkV[d], tmoV[d]}, 32'd0);
      checkOutput($sformatf("d%0d reset id_value", d), idVal[d], 32'd0);
    end
    resetN = 1'b1;

    // Directed scenarios: nominal, wrong id, stalled timestamp, timeouts on each word.
    applyStimulus(0, 0, 0, EXP_ID, EXP_TS);
    applyStimulus(0, 0, 0, 32'h1, EXP_TS);
    applyStimulus(0, 0, 5, EXP_ID, EXP_TS);
    applyStimulus(1, STUCK, 0, EXP_ID, EXP_TS);
    applyStimulus(1, 1, STUCK, 32'hDEAD_BEEF, EXP_TS);
    applyStimulus(1, 3, 4, EXP_ID, EXP_TS);
    applyStimulus(1, 3, 3, EXP_ID, EXP_TS);

    // Reset pulse while reading the timestamp word.
    stallCfg[0][0] = 0;
    stallCfg[0][1] = 3;
    @(negedge clock);
    startV[0] = 1'b1;
    @(negedge clock);
    startV[0] = 1'b0;
    @(negedge clock);
    checkOutput("rst pre addr", 32'(avmAddress[0]), 32'd1);
    checkOutput("rst pre read", 32'(avmRead[0]), 32'd1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("rst read", 32'(avmRead[0]), 32'd0);
    checkOutput("rst busy", 32'(busyV[0]), 32'd0);
    checkOutput("rst id_value", idVal[0], 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    for (int d = 0; d < 2; d++) begin
      prevId[d] = '0;
      prevTs[d] = '0;
    end
    applyStimulus(0, 0, 0, EXP_ID, EXP_TS);

    // Randomized sequences; instance B's stall range straddles its timeout.
    for (int n = 0; n < 16; n++) begin
      int          d;
      logic [31:0] vId, vTs;
      d   = n % 2;
      vId = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_ID;
      vTs = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_TS;
      applyStimulus(d, $urandom_range(0, d ? 5 : 6), $urandom_range(0, d ? 5 : 6), vId, vTs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
